// File: rtl/hub75_bcm_scanner.sv
// hub75_bcm_scanner: HUB75 row scan/shift/latch/display sequencer with binary-code-modulated brightness.
module hub75_bcm_scanner #(
  parameter int WIDTH    = 64,
  parameter int ROW_BITS = 4,
  parameter int PLANES   = 4,
  parameter int BASE_OE  = 8,
  parameter int BLANK    = 2,
  localparam int XW = $clog2(WIDTH),
  localparam int PW = (PLANES > 1) ? $clog2(PLANES) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic                led_clk,
  output logic                led_latch,
  output logic                led_oe,
  output logic [ROW_BITS-1:0] row,
  output logic [XW-1:0]       x,
  output logic [ROW_BITS-1:0] rd_row,
  output logic [PW-1:0]       rd_plane,
  output logic                frame_start
);
  localparam int DMAX = BASE_OE << (PLANES - 1);
  localparam int CW = $clog2(((DMAX > BLANK) ? DMAX : BLANK) + 1);
  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_LATCH, S_DISPLAY, S_BLANK} state_t;
  state_t state_q, state_d;
  logic [XW-1:0] x_q, x_d;
  logic [CW-1:0] cnt_q, cnt_d, disp_last;
  logic [ROW_BITS-1:0] row_q, row_d, rd_row_q, rd_row_d;
  logic [PW-1:0] rd_plane_q, rd_plane_d;
  logic shift_en_q, shift_en_d;
  assign disp_last = CW'((BASE_OE << rd_plane_q) - 1);
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    cnt_d = cnt_q;
    row_d = row_q;
    rd_row_d = rd_row_q;
    rd_plane_d = rd_plane_q;
    case (state_q)
      S_IDLE: state_d = en ? S_SHIFT : S_IDLE;
      S_SHIFT: begin
        x_d = (x_q == XW'(WIDTH - 1)) ? '0 : x_q + XW'(1);
        if (x_q == XW'(WIDTH - 1)) begin
          state_d = S_LATCH;
          row_d = rd_row_q;
        end
      end
      S_LATCH: begin
        state_d = S_DISPLAY;
        cnt_d = '0;
      end
      S_DISPLAY: begin
        state_d = (cnt_q == disp_last) ? S_BLANK : S_DISPLAY;
        cnt_d = (cnt_q == disp_last) ? '0 : cnt_q + CW'(1);
      end
      S_BLANK: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(BLANK - 1)) begin
          cnt_d = '0;
          state_d = en ? S_SHIFT : S_IDLE;
          rd_plane_d = (rd_plane_q == PW'(PLANES - 1)) ? '0 : rd_plane_q + PW'(1);
          rd_row_d = (rd_plane_q == PW'(PLANES - 1)) ? rd_row_q + ROW_BITS'(1) : rd_row_q;
        end
      end
      default: state_d = S_IDLE;
    endcase
    shift_en_d = (state_d == S_SHIFT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      x_q <= '0;
      cnt_q <= '0;
      row_q <= '0;
      rd_row_q <= '0;
      rd_plane_q <= '0;
      shift_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      cnt_q <= cnt_d;
      row_q <= row_d;
      rd_row_q <= rd_row_d;
      rd_plane_q <= rd_plane_d;
      shift_en_q <= shift_en_d;
    end
  end
  assign led_clk = ~clk & shift_en_q;
  assign led_latch = (state_q == S_LATCH);
  assign led_oe = (state_q == S_DISPLAY);
  assign row = row_q;
  assign x = x_q;
  assign rd_row = rd_row_q;
  assign rd_plane = rd_plane_q;
  assign frame_start = (state_q == S_SHIFT) && (x_q == '0) && (rd_row_q == '0) && (rd_plane_q == '0);
endmodule

// File: tb/tb_hub75_bcm_scanner.sv
// tb_hub75_bcm_scanner: scoreboard bench for the HUB75 BCM scanner (small and default parameter sets).
module tb_hub75_bcm_scanner;
  localparam int W = 4, RB = 1, PL = 2, BO = 2, BL = 1;
  logic clk = 1'b0;
  logic rst, en;
  logic led_clk, led_latch, led_oe, frame_start;
  logic [1:0] x;
  logic [0:0] row, rd_row, rd_plane;
  logic d_led_clk, d_led_latch, d_led_oe, d_frame_start;
  logic [5:0] d_x;
  logic [3:0] d_row, d_rd_row;
  logic [1:0] d_rd_plane;
  typedef struct packed {
    logic fs;
    logic latch;
    logic oe;
    logic sh;
    logic [1:0] x;
    logic row;
    logic rd_row;
    logic rd_plane;
  } obs_t;
  obs_t sb[$];
  int n_chk = 0, n_fail = 0;
  int mr = 0, mp = 0, lrow = 0;
  int nclk = 0, n_overlap = 0;
  hub75_bcm_scanner #(.WIDTH(W), .ROW_BITS(RB), .PLANES(PL), .BASE_OE(BO), .BLANK(BL)) dut (
    .clk(clk), .rst(rst), .en(en), .led_clk(led_clk), .led_latch(led_latch), .led_oe(led_oe),
    .row(row), .x(x), .rd_row(rd_row), .rd_plane(rd_plane), .frame_start(frame_start)
  );
  hub75_bcm_scanner dut_def (
    .clk(clk), .rst(rst), .en(en), .led_clk(d_led_clk), .led_latch(d_led_latch), .led_oe(d_led_oe),
    .row(d_row), .x(d_x), .rd_row(d_rd_row), .rd_plane(d_rd_plane), .frame_start(d_frame_start)
  );
  always #5 clk = ~clk;
  always @(posedge led_clk) nclk <= nclk + 1;
  always @(posedge clk) if ((led_latch && led_oe) || (d_led_latch && d_led_oe)) n_overlap <= n_overlap + 1;
  function automatic obs_t sample();
    return '{frame_start, led_latch, led_oe, led_clk, x, row, rd_row, rd_plane};
  endfunction
  task automatic push(logic fs, logic la, logic oe, logic sh, logic [1:0] xx, int rw, int rr, int rp);
    sb.push_back('{fs, la, oe, sh, xx, 1'(rw), 1'(rr), 1'(rp)});
  endtask
  task automatic push_idle();
    push(0, 0, 0, 0, 0, lrow, mr, mp);
  endtask
  task automatic push_slot();
    for (int i = 0; i < W; i++) push(i == 0 && mr == 0 && mp == 0, 0, 0, 1, 2'(i), lrow, mr, mp);
    lrow = mr;
    push(0, 1, 0, 0, 0, mr, mr, mp);
    for (int i = 0; i < (BO << mp); i++) push(0, 0, 1, 0, 0, mr, mr, mp);
    for (int i = 0; i < BL; i++) push(0, 0, 0, 0, 0, mr, mr, mp);
    if (mp == PL - 1) begin
      mp = 0;
      mr = (mr + 1) % (1 << RB);
    end else mp++;
  endtask
  task automatic test_reset();
    obs_t o, e;
    rst = 1'b1;
    en = 1'b0;
    mr = 0; mp = 0; lrow = 0;
    sb.delete();
    repeat (3) push_idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      o = sample(); e = sb.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL reset cyc %0d: got %b expected %b", c, o, e); end
    end
  endtask
  task automatic test_startup();
    obs_t o, e;
    rst = 1'b0;
    en = 1'b1;
    push_idle();
    #1;
    o = sample(); e = sb.pop_front(); n_chk++;
    if (o !== e) begin n_fail++; $display("FAIL startup_idle: got %b expected %b", o, e); end
    push_slot();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      o = sample(); e = sb.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL startup cyc %0d: got %b expected %b", c, o, e); end
    end
  endtask
  task automatic test_free_run();
    obs_t o, e;
    int oe_cnt, fs_cnt, flips, bad_flip;
    logic prev_row;
    oe_cnt = 0; fs_cnt = 0; flips = 0; bad_flip = 0;
    prev_row = row;
    repeat (4) push_slot();
    for (int c = 0; c < 36; c++) begin
      @(negedge clk); #1;
      o = sample(); e = sb.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL free_run cyc %0d: got %b expected %b", c, o, e); end
      if (led_oe) oe_cnt++;
      if (frame_start) fs_cnt++;
      if (row !== prev_row) begin
        flips++;
        if (!led_latch) bad_flip++;
      end
      prev_row = row;
    end
    n_chk++;
    if (oe_cnt !== 12) begin n_fail++; $display("FAIL free_run_oe_cycles: got %0d expected 12", oe_cnt); end
    n_chk++;
    if (fs_cnt !== 1) begin n_fail++; $display("FAIL free_run_frame_start: got %0d expected 1", fs_cnt); end
    n_chk++;
    if (flips !== 2 || bad_flip !== 0) begin
      n_fail++; $display("FAIL free_run_row_flips: got %0d flips (%0d outside latch) expected 2 (0)", flips, bad_flip);
    end
  endtask
  task automatic test_led_clk();
    obs_t o, e;
    int snap;
    snap = nclk;
    repeat (4) push_slot();
    for (int c = 0; c < 36; c++) begin
      @(negedge clk); #1;
      o = sample(); e = sb.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL led_clk cyc %0d: got %b expected %b", c, o, e); end
    end
    n_chk++;
    if (nclk - snap !== 16) begin n_fail++; $display("FAIL led_clk_edges: got %0d expected 16", nclk - snap); end
    n_chk++;
    if (n_overlap !== 0) begin n_fail++; $display("FAIL latch_oe_overlap: got %0d expected 0", n_overlap); end
  endtask
  task automatic test_en_drop();
    obs_t o, e;
    push_slot();
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      o = sample(); e = sb.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL en_drop cyc %0d: got %b expected %b", c, o, e); end
      if (c == 5) en = 1'b0;
    end
    repeat (3) push_idle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      o = sample(); e = sb.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL en_idle cyc %0d: got %b expected %b", c, o, e); end
    end
    en = 1'b1;
    push_slot();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      o = sample(); e = sb.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL en_resume cyc %0d: got %b expected %b", c, o, e); end
      if (c == 1) en = 1'b0;
      if (c == 4) en = 1'b1;
    end
  endtask
  task automatic test_reset_mid();
    obs_t o, e;
    push_slot();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      o = sample(); e = sb.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL mid_shift cyc %0d: got %b expected %b", c, o, e); end
    end
    rst = 1'b1;
    sb.delete();
    mr = 0; mp = 0; lrow = 0;
    repeat (2) push_idle();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); #1;
      o = sample(); e = sb.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL mid_reset cyc %0d: got %b expected %b", c, o, e); end
    end
    rst = 1'b0;
    push_slot();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      o = sample(); e = sb.pop_front(); n_chk++;
      if (o !== e) begin n_fail++; $display("FAIL mid_restart cyc %0d: got %b expected %b", c, o, e); end
    end
  endtask
  task automatic test_defaults();
    int first_fs, period, p3len, run;
    logic [1:0] last_plane;
    first_fs = -1; period = -1; p3len = -1; run = 0;
    last_plane = d_rd_plane;
    for (int c = 0; c < 20000 && (period < 0 || p3len < 0); c++) begin
      @(negedge clk); #1;
      if (d_frame_start) begin
        if (first_fs < 0) first_fs = c;
        else if (period < 0) period = c - first_fs;
      end
      if (d_led_oe) run++;
      else begin
        if (run > 0 && last_plane == 2'd3 && p3len < 0) p3len = run;
        run = 0;
      end
      last_plane = d_rd_plane;
    end
    n_chk++;
    if (period !== 6208) begin n_fail++; $display("FAIL default_frame_period: got %0d expected 6208", period); end
    n_chk++;
    if (p3len !== 64) begin n_fail++; $display("FAIL default_plane3_oe: got %0d expected 64", p3len); end
    n_chk++;
    if (n_overlap !== 0) begin n_fail++; $display("FAIL default_latch_oe_overlap: got %0d expected 0", n_overlap); end
  endtask
  initial begin
    rst = 1'b1;
    en = 1'b0;
    test_reset();
    test_startup();
    test_free_run();
    test_led_clk();
    test_en_drop();
    test_reset_mid();
    test_defaults();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
